seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 1000, CLK cycles per digit slot; legal range CLK_DIV >= GUARD+2.
REQ-002 SHALL provide parameter GUARD, default 4, CLK cycles at the start of each slot with all digit enables off (anti-ghosting); legal range GUARD >= 0.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RST  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port VALUE  input  16  four hex digits; [3:0]=digit 0 (rightmost), [15:12]=digit 3.
REQ-006 SHALL have port LOAD  input  1  one-cycle strobe capturing VALUE into the pending register.
REQ-007 SHALL have port LZB  input  1  leading-zero blanking enable, sampled every cycle.
REQ-008 SHALL have port NIBBLE  output  4  nibble of the current digit, to the registered 7-segment decoder D input.
REQ-009 SHALL have port AN  output  4  registered one-hot digit enable, active-high; AN[i] lights digit i.
REQ-010 SHALL have port PENDING  output  1  high while a loaded value awaits transfer to display.
REQ-011 SHALL have port FRAME  output  1  registered one-cycle pulse at the start of each new frame.

Function
REQ-012 SHALL keep slot counter cnt (0..CLK_DIV-1) incrementing every cycle; at CLK_DIV-1 it wraps to 0 and digit index idx advances 0->1->2->3->0.
REQ-013 SHALL drive NIBBLE combinationally as shadow[4*idx+3 : 4*idx], changing in the same cycle as idx.
REQ-014 SHALL register AN each cycle: AN <= onehot(idx) when cnt >= GUARD and digit idx is not blanked, else 4'b0000; this one-cycle lag aligns AN with the decoder's registered SEG output.
REQ-015 SHALL blank digits only when LZB=1: digit 3 if shadow[15:12]==0; digit 2 if shadow[15:8]==0; digit 1 if shadow[15:4]==0; digit 0 never.
REQ-016 SHALL, on LOAD=1, capture VALUE into the pending register and set PENDING=1; a further LOAD while PENDING=1 overwrites the pending value (last wins).
REQ-017 SHALL transfer pending to shadow only at frame end (cnt==CLK_DIV-1 and idx==3) while PENDING=1, clearing PENDING in the same edge; the displayed value never changes mid-frame.
REQ-018 SHALL, when LOAD coincides with a frame-end transfer, move the old pending value to shadow, capture the new VALUE into pending, and leave PENDING=1.
REQ-019 SHALL, when LOAD arrives at frame end with PENDING=0, perform no transfer; the value is shown from the following frame end.
REQ-020 SHALL assert FRAME for exactly one cycle, registered from (cnt==CLK_DIV-1 and idx==3), i.e. high in the cycle where cnt==0, idx==0; no pulse follows reset release.
REQ-021 SHALL size cnt as ceil(log2(CLK_DIV)) bits, never exceed CLK_DIV-1, and make one frame exactly 4*CLK_DIV cycles.

Reset
REQ-022 SHALL, in the cycle after any edge with RST=1, have cnt=0, idx=0, shadow=0, pending=0, PENDING=0, AN=4'b0000, FRAME=0, NIBBLE=4'h0.
REQ-023 SHALL give RST priority over LOAD and over an in-progress transfer; a LOAD coincident with RST is discarded.
REQ-024 SHALL hold all outputs at reset values while RST stays high, resuming counting from cnt=0 on the first edge with RST=0.

Verification (CLK_DIV=8, GUARD=2)
REQ-025 SHALL cover free-run after reset, LZB=0: AN repeats 00,00,0001 x6, 00,00,0010 x6, 00,00,0100 x6, 00,00,1000 x6 (32-cycle period, first two cycles of each slot off), NIBBLE=0 throughout, FRAME pulse every 32 cycles, none at reset release.
REQ-026 SHALL cover LOAD of 16'h1234 mid-slot of digit 1: PENDING=1 immediately, NIBBLE stays 0 until frame end, then PENDING=0, FRAME pulses, NIBBLE sequence 4,3,2,1 per slot.
REQ-027 SHALL cover LZB=1 with 16'h0042: AN[3] and AN[2] never asserted, AN[1]/AN[0] as REQ-025; with 16'h0000 only AN[0] ever asserts; with 16'h0100 digits 2,1,0 active.
REQ-028 SHALL cover two LOADs (16'hAAAA then 16'h5555) in one frame: 16'h5555 displayed; LOAD of 16'hBEEF exactly at frame-end transfer: 16'h5555 shown, PENDING stays 1, 16'hBEEF shown one frame later.
REQ-029 SHALL cover RST asserted mid-slot of digit 2 with PENDING=1: next cycle AN=0000, PENDING=0, NIBBLE=0, FRAME=0; after release timing restarts exactly as REQ-025.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller.
// Double-buffered value, guard-band blanking, optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int CLK_DIV = 1000,
  parameter int GUARD   = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] VALUE,
  input  logic        LOAD,
  input  logic        LZB,
  output logic [3:0]  NIBBLE,
  output logic [3:0]  AN,
  output logic        PENDING,
  output logic        FRAME
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GRD  = CW'(GUARD);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   pend_val;
  logic          pend;
  logic [3:0]    an_q;
  logic          frame_q;
  logic          last;
  logic          fend;
  logic          blank;
  logic          lit;

  always_comb begin
    last = (cnt == LAST);
    fend = last && (idx == 2'd3);
    blank = 1'b0;
    unique case (idx)
      2'd3: blank = LZB && (shadow[15:12] == 4'h0);
      2'd2: blank = LZB && (shadow[15:8] == 8'h00);
      2'd1: blank = LZB && (shadow[15:4] == 12'h000);
      2'd0: blank = 1'b0;
    endcase
    lit = (cnt >= GRD) && !blank;
    NIBBLE = shadow[{idx, 2'b00} +: 4];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      idx      <= 2'd0;
      shadow   <= 16'h0000;
      pend_val <= 16'h0000;
      pend     <= 1'b0;
      an_q     <= 4'b0000;
      frame_q  <= 1'b0;
    end else begin
      cnt     <= last ? '0 : cnt + 1'b1;
      idx     <= last ? idx + 2'd1 : idx;
      frame_q <= fend;
      an_q    <= lit ? (4'b0001 << idx) : 4'b0000;
      if (fend && pend) begin
        shadow <= pend_val;
        pend   <= 1'b0;
      end
      // A new load wins over the clear from a simultaneous transfer
      if (LOAD) begin
        pend_val <= VALUE;
        pend     <= 1'b1;
      end
    end
  end

  assign AN      = an_q;
  assign PENDING = pend;
  assign FRAME   = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (CLK_DIV=8, GUARD=2).
// Expected outputs are queued as stimulus is driven and popped after each edge.
module tb_seg_scan_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [15:0] VALUE = 16'h0000;
  logic        LOAD = 1'b0;
  logic        LZB = 1'b0;
  logic [3:0]  NIBBLE;
  logic [3:0]  AN;
  logic        PENDING;
  logic        FRAME;

  seg_scan_ctrl #(.CLK_DIV(8), .GUARD(2)) dut (
    .CLK(CLK), .RST(RST), .VALUE(VALUE), .LOAD(LOAD), .LZB(LZB),
    .NIBBLE(NIBBLE), .AN(AN), .PENDING(PENDING), .FRAME(FRAME)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] an;
    logic [3:0] nib;
    logic       pend;
    logic       frame;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int n = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic [15:0] m_pv = 16'h0000;
  logic        m_pf = 1'b0;
  logic        cur_lz = 1'b0;

  function automatic logic blanked(input logic [15:0] s, input int ix,
                                   input logic lz);
    return lz && ((ix == 3 && s[15:12] == 4'h0) ||
                  (ix == 2 && s[15:8] == 8'h00) ||
                  (ix == 1 && s[15:4] == 12'h000));
  endfunction

  task automatic tick(input logic ld, input logic [15:0] v, input logic rs);
    exp_t e;
    exp_t o;
    int c;
    int ix;
    LOAD = ld;
    VALUE = v;
    LZB = cur_lz;
    RST = rs;
    if (rs) begin
      n = 0;
      m_shadow = 16'h0000;
      m_pv = 16'h0000;
      m_pf = 1'b0;
      e = '{4'b0000, 4'h0, 1'b0, 1'b0};
    end else begin
      c = n % 8;
      ix = (n / 8) % 4;
      e.an = (c >= 2 && !blanked(m_shadow, ix, cur_lz)) ?
             (4'b0001 << ix) : 4'b0000;
      e.frame = (c == 7 && ix == 3);
      if (e.frame && m_pf) begin
        m_shadow = m_pv;
        m_pf = 1'b0;
      end
      if (ld) begin
        m_pv = v;
        m_pf = 1'b1;
      end
      n++;
      e.nib = m_shadow[4*((n/8)%4) +: 4];
      e.pend = m_pf;
    end
    q.push_back(e);
    @(posedge CLK);
    #1;
    o = q.pop_front();
    checks++;
    assert (AN === o.an) else begin
      errors++;
      $error("FAIL an n=%0d obs=%b exp=%b", n, AN, o.an);
    end
    checks++;
    assert (NIBBLE === o.nib) else begin
      errors++;
      $error("FAIL nibble n=%0d obs=%h exp=%h", n, NIBBLE, o.nib);
    end
    checks++;
    assert (PENDING === o.pend) else begin
      errors++;
      $error("FAIL pending n=%0d obs=%b exp=%b", n, PENDING, o.pend);
    end
    checks++;
    assert (FRAME === o.frame) else begin
      errors++;
      $error("FAIL frame n=%0d obs=%b exp=%b", n, FRAME, o.frame);
    end
    LOAD = 1'b0;
  endtask

  task automatic run(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 16'h0000, 1'b0);
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 40 && (n % 32) != p; i++)
      tick(1'b0, 16'h0000, 1'b0);
  endtask

  initial begin
    @(posedge CLK);
    #1;
    // Held reset, with a coincident load that must be discarded
    tick(1'b0, 16'h0000, 1'b1);
    tick(1'b1, 16'hFFFF, 1'b1);
    tick(1'b0, 16'h0000, 1'b1);
    // Free run, no blanking
    run(70);
    // Load mid-slot of digit 1
    run_to(11);
    tick(1'b1, 16'h1234, 1'b0);
    run(60);
    // Leading-zero blanking patterns
    cur_lz = 1'b1;
    tick(1'b1, 16'h0042, 1'b0);
    run(70);
    tick(1'b1, 16'h0000, 1'b0);
    run(70);
    tick(1'b1, 16'h0100, 1'b0);
    run(70);
    cur_lz = 1'b0;
    // Two loads in one frame, then a load exactly at frame end
    run_to(5);
    tick(1'b1, 16'hAAAA, 1'b0);
    run_to(15);
    tick(1'b1, 16'h5555, 1'b0);
    run_to(31);
    tick(1'b1, 16'hBEEF, 1'b0);
    run(70);
    // Reset mid-slot of digit 2 with a pending value
    run_to(17);
    tick(1'b1, 16'hC0DE, 1'b0);
    run_to(20);
    tick(1'b0, 16'h0000, 1'b1);
    run(70);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
